// File: rtl/ro_freq_meter.sv
// Ring-oscillator controller and frequency meter: enables the oscillator, waits a
// settle time, then counts synchronized ro_clk rising edges over a fixed clk gate window.
module ro_freq_meter #(
  parameter int unsigned GATE_CYCLES   = 100000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned COUNT_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   meas_start,
  input  logic                   continuous,
  input  logic                   abort,
  input  logic                   ro_clk,
  output logic                   ro_enable,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   count_valid,
  output logic                   overflow
);

  localparam int unsigned MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0]          SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]          GATE_LAST   = TW'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 r_state;
  logic [TW-1:0]          r_timer;
  logic [COUNT_WIDTH-1:0] r_edge_cnt;
  logic                   r_ovf;
  logic                   r_s1;
  logic                   r_s2;
  logic                   r_s3;
  logic                   r_ro_enable;
  logic                   r_busy;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_count_valid;
  logic                   r_overflow;
  logic                   w_rise;

  assign w_rise = r_s2 & ~r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_edge_cnt    <= '0;
      r_ovf         <= 1'b0;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      r_ro_enable   <= 1'b0;
      r_busy        <= 1'b0;
      r_count       <= '0;
      r_count_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      // ro_clk is asynchronous: two-flop synchronizer plus one stage for edge detect
      r_s1          <= ro_clk;
      r_s2          <= r_s1;
      r_s3          <= r_s2;
      r_count_valid <= 1'b0;

      if (abort && (r_state != S_IDLE)) begin
        r_state     <= S_IDLE;
        r_ro_enable <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (meas_start) begin
              r_state     <= S_SETTLE;
              r_timer     <= '0;
              r_ro_enable <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
          S_SETTLE: begin
            if (r_timer == SETTLE_LAST) begin
              r_state    <= S_GATE;
              r_timer    <= '0;
              r_edge_cnt <= '0;
              r_ovf      <= 1'b0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_GATE: begin
            // Saturating count; the flag marks that at least one edge was lost
            if (w_rise) begin
              if (r_edge_cnt == CNT_MAX) begin
                r_ovf <= 1'b1;
              end else begin
                r_edge_cnt <= r_edge_cnt + 1'b1;
              end
            end
            if (r_timer == GATE_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_DONE: begin
            r_count       <= r_edge_cnt;
            r_overflow    <= r_ovf;
            r_count_valid <= 1'b1;
            if (continuous) begin
              r_state <= S_SETTLE;
              r_timer <= '0;
            end else begin
              r_state     <= S_IDLE;
              r_ro_enable <= 1'b0;
              r_busy      <= 1'b0;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_ro_enable <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ro_enable   = r_ro_enable;
  assign busy        = r_busy;
  assign count       = r_count;
  assign count_valid = r_count_valid;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: latency, edge counts, saturation, continuous
// mode, abort and mid-measurement reset, with hand-computed expectations.
module tb_ro_freq_meter;

  logic       clk;
  logic       rst;
  logic       meas_start;
  logic       meas_start3;
  logic       continuous;
  logic       abort;
  logic       ro_clk;
  logic       ro_clk3;
  logic       ro_run;

  logic       ro_enable;
  logic       busy;
  logic [7:0] count;
  logic       count_valid;
  logic       overflow;

  logic       ro_enable3;
  logic       busy3;
  logic [2:0] count3;
  logic       count_valid3;
  logic       overflow3;

  int n_checks = 0;
  int n_errors = 0;

  ro_freq_meter #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .COUNT_WIDTH(8)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .meas_start  (meas_start),
    .continuous  (continuous),
    .abort       (abort),
    .ro_clk      (ro_clk),
    .ro_enable   (ro_enable),
    .busy        (busy),
    .count       (count),
    .count_valid (count_valid),
    .overflow    (overflow)
  );

  ro_freq_meter #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .COUNT_WIDTH(3)) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .meas_start  (meas_start3),
    .continuous  (continuous),
    .abort       (abort),
    .ro_clk      (ro_clk3),
    .ro_enable   (ro_enable3),
    .busy        (busy3),
    .count       (count3),
    .count_valid (count_valid3),
    .overflow    (overflow3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator models, phase-offset so their edges never coincide with a clk edge
  initial begin
    ro_clk = 1'b0;
    #2;
    forever begin
      #50 ro_clk = ro_run ? ~ro_clk : 1'b0;
    end
  end

  initial begin
    ro_clk3 = 1'b0;
    #2;
    forever begin
      #20 ro_clk3 = ~ro_clk3;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse meas_start for one cycle, return cycles until count_valid (0 on timeout)
  task automatic measure(input bit use3, output int lat);
    @(negedge clk);
    if (use3) meas_start3 = 1'b1; else meas_start = 1'b1;
    @(negedge clk);
    meas_start  = 1'b0;
    meas_start3 = 1'b0;
    lat = 1;
    check("start_ro_enable", use3 ? ro_enable3 : ro_enable, 1);
    while (!(use3 ? count_valid3 : count_valid) && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 400) lat = 0;
  endtask

  // Wait for the next count_valid, return elapsed cycles and whether ro_enable ever dropped
  task automatic next_valid(output int n, output bit dropped);
    n = 0;
    dropped = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!ro_enable) dropped = 1'b1;
    end while (!count_valid && n < 400);
    if (n >= 400) n = 0;
  endtask

  initial begin
    int  lat;
    int  seen;
    bit  dropped;

    rst = 1'b1; meas_start = 1'b0; meas_start3 = 1'b0;
    continuous = 1'b0; abort = 1'b0; ro_run = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ro_enable", ro_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_valid", count_valid, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);

    // 1: 100 ns oscillator, single measurement
    check("t1_ro_en_before", ro_enable, 0);
    measure(1'b0, lat);
    check("t1_latency", 32'(lat), 106);
    check("t1_count", count, 10);
    check("t1_overflow", overflow, 0);
    @(negedge clk);
    check("t1_valid_one_cycle", count_valid, 0);
    check("t1_ro_en_off", ro_enable, 0);

    // 2: oscillator stopped
    ro_run = 1'b0;
    repeat (20) @(negedge clk);
    measure(1'b0, lat);
    check("t2_latency", 32'(lat), 106);
    check("t2_count", count, 0);
    check("t2_ro_en_off", ro_enable, 0);
    check("t2_busy_off", busy, 0);
    ro_run = 1'b1;
    repeat (20) @(negedge clk);

    // 3: 3-bit counter, 25 edges saturate
    measure(1'b1, lat);
    check("t3_latency", 32'(lat), 106);
    check("t3_count", count3, 7);
    check("t3_overflow", overflow3, 1);

    // 4: continuous mode
    continuous = 1'b1;
    measure(1'b0, lat);
    check("t4_first_latency", 32'(lat), 106);
    check("t4_first_count", count, 10);
    for (int k = 0; k < 3; k++) begin
      next_valid(lat, dropped);
      check("t4_period", 32'(lat), 105);
      check("t4_count", count, 10);
      check("t4_overflow", overflow, 0);
      check("t4_ro_en_held", 32'(dropped), 0);
    end
    continuous = 1'b0;
    next_valid(lat, dropped);
    check("t4_last_period", 32'(lat), 105);
    check("t4_last_count", count, 10);
    check("t4_stop_ro_en", ro_enable, 0);
    check("t4_stop_busy", busy, 0);

    // 5: abort in the 50th gate cycle
    @(negedge clk);
    meas_start = 1'b1;
    @(negedge clk);
    meas_start = 1'b0;
    repeat (53) @(negedge clk);
    check("t5_busy_in_gate", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort_ro_en", ro_enable, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_valid", count_valid, 0);
    check("t5_abort_count", count, 10);
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (count_valid) seen++;
    end
    check("t5_no_valid", 32'(seen), 0);
    check("t5_count_held", count, 10);

    // 6: reset in the middle of a gate window
    @(negedge clk);
    meas_start = 1'b1;
    @(negedge clk);
    meas_start = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_ro_en", ro_enable, 0);
    check("t6_busy", busy, 0);
    check("t6_count", count, 0);
    check("t6_valid", count_valid, 0);
    check("t6_overflow", overflow, 0);
    repeat (5) @(negedge clk);
    measure(1'b0, lat);
    check("t6_latency", 32'(lat), 106);
    check("t6_count_after", count, 10);
    check("t6_overflow_after", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
